// File: rtl/objects_pkg.sv
// Shared definitions for the layered object compositor.
package objects_pkg;

  localparam int unsigned RGB_WIDTH_DEF       = 8;
  localparam logic [7:0]  TRANSPARENT_RGB_DEF = 8'hFF;
  localparam int unsigned LAYER_IDX_W         = 4;

  // Wide enough to index up to 16 layers.
  typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

  // Fixed drawing order: lower index wins.
  localparam layer_idx_t BALL        = 4'd0;
  localparam layer_idx_t FLIPPER     = 4'd1;
  localparam layer_idx_t OBSTACLE    = 4'd2;
  localparam layer_idx_t INDICATIONS = 4'd3;
  localparam layer_idx_t SPRING      = 4'd4;
  localparam layer_idx_t BUMPER      = 4'd5;

endpackage

// File: rtl/layer_priority_encoder.sv
// Lowest-index-wins priority encoder over the effective draw vector.
module layer_priority_encoder
  import objects_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 6
) (
  input  logic [NUM_LAYERS-1:0] eff,
  output logic                  valid_c,
  output layer_idx_t            index_c
);

  // Scan from highest to lowest index so the lowest set bit is the last one written.
  always_comb begin
    valid_c = 1'b0;
    index_c = '0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (eff[i]) begin
        valid_c = 1'b1;
        index_c = layer_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// Layered object compositor: priority mux with blink, two-stage pipeline and
// per-frame collision reporting between layer 0 and every other layer.
module objects_mux_layered
  import objects_pkg::*;
#(
  parameter int unsigned           NUM_LAYERS      = 6,
  parameter int unsigned           RGB_WIDTH       = RGB_WIDTH_DEF,
  parameter logic [RGB_WIDTH-1:0]  TRANSPARENT_RGB = RGB_WIDTH'(TRANSPARENT_RGB_DEF),
  parameter int unsigned           BLINK_LOG2      = 5
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 startOfFrame,
  input  logic [NUM_LAYERS-1:0]                draw,
  input  logic [NUM_LAYERS-1:0][RGB_WIDTH-1:0] RGB_layers,
  input  logic [RGB_WIDTH-1:0]                 RGB_backGround,
  input  logic [NUM_LAYERS-1:0]                layerEnable,
  input  logic [NUM_LAYERS-1:0]                blinkMask,
  output logic [RGB_WIDTH-1:0]                 RGB_screen,
  output logic                                 drawAny,
  output logic [NUM_LAYERS-1:0]                collision,
  output logic                                 collisionValid
);

  localparam int unsigned FC_W        = BLINK_LOG2 + 1;
  localparam layer_idx_t  LAYER_LIMIT = layer_idx_t'(NUM_LAYERS - 1);

  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] hits;
  logic [NUM_LAYERS-1:0] coll_acc;
  logic                  win_valid;
  layer_idx_t            win_idx;
  logic [RGB_WIDTH-1:0]  win_rgb;

  logic                  s1_valid;
  layer_idx_t            s1_idx;
  logic [RGB_WIDTH-1:0]  s1_rgb;

  assign blink_phase = frame_cnt[FC_W-1];

  // Effective draw per layer and layer-0 overlap hits for this pixel.
  always_comb begin
    eff  = '0;
    hits = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      eff[i] = draw[i] & layerEnable[i] & (~blinkMask[i] | blink_phase)
             & (RGB_layers[i] != TRANSPARENT_RGB);
    end
    for (int k = 1; k < int'(NUM_LAYERS); k++) begin
      hits[k] = eff[0] & eff[k];
    end
  end

  layer_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_prio (
    .eff     (eff),
    .valid_c (win_valid),
    .index_c (win_idx)
  );

  // Winning colour select; background when no layer is effective.
  always_comb begin
    win_rgb = RGB_backGround;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (win_valid && (win_idx == layer_idx_t'(i))) begin
        win_rgb = RGB_layers[i];
      end
    end
  end

  // Blink frame counter, advances once per frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
    end else if (startOfFrame) begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  // Pipeline stage 1: winner index, valid and colour.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= win_valid;
      s1_idx   <= win_idx;
      s1_rgb   <= win_rgb;
    end
  end

  // Pipeline stage 2: screen outputs; index range guard keeps drawAny tied to a legal layer.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGB_screen <= '0;
      drawAny    <= 1'b0;
    end else begin
      RGB_screen <= s1_rgb;
      drawAny    <= s1_valid & (s1_idx <= LAYER_LIMIT);
    end
  end

  // Collision accumulation; the startOfFrame cycle closes the previous frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_acc       <= '0;
      collision      <= '0;
      collisionValid <= 1'b0;
    end else if (startOfFrame) begin
      collision      <= coll_acc | hits;
      coll_acc       <= '0;
      collisionValid <= 1'b1;
    end else begin
      coll_acc       <= coll_acc | hits;
      collisionValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_objects_mux_layered.sv
// Directed self-checking bench for objects_mux_layered (default parameters).
module tb_objects_mux_layered;

  logic            clk = 1'b0;
  logic            resetN;
  logic            startOfFrame;
  logic [5:0]      draw;
  logic [5:0][7:0] RGB_layers;
  logic [7:0]      RGB_backGround;
  logic [5:0]      layerEnable;
  logic [5:0]      blinkMask;
  logic [7:0]      RGB_screen;
  logic            drawAny;
  logic [5:0]      collision;
  logic            collisionValid;

  int checks = 0;
  int errors = 0;

  objects_mux_layered dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .draw           (draw),
    .RGB_layers     (RGB_layers),
    .RGB_backGround (RGB_backGround),
    .layerEnable    (layerEnable),
    .blinkMask      (blinkMask),
    .RGB_screen     (RGB_screen),
    .drawAny        (drawAny),
    .collision      (collision),
    .collisionValid (collisionValid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
  endtask

  initial begin
    resetN         = 1'b0;
    startOfFrame   = 1'b0;
    draw           = '0;
    RGB_layers     = '0;
    RGB_backGround = 8'h92;
    layerEnable    = 6'b111111;
    blinkMask      = '0;
    step();
    check("reset_rgb", 32'(RGB_screen), 32'h0);
    check("reset_drawany", 32'(drawAny), 32'h0);
    check("reset_coll", 32'(collision), 32'h0);
    check("reset_cvalid", 32'(collisionValid), 32'h0);

    // Release with ball drawn: first output cycles stay zero.
    RGB_layers[0] = 8'h1C;
    RGB_layers[5] = 8'hE0;
    draw          = 6'b100001;
    resetN        = 1'b1;
    #1;
    check("post_rst0_rgb", 32'(RGB_screen), 32'h0);
    step();
    check("post_rst1_rgb", 32'(RGB_screen), 32'h0);
    check("post_rst1_drawany", 32'(drawAny), 32'h0);
    step();
    check("ball_bumper_rgb", 32'(RGB_screen), 32'h1C);
    check("ball_bumper_drawany", 32'(drawAny), 32'h1);
    draw = '0;
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check("ball_bumper_coll", 32'(collision), 32'h20);
    check("ball_bumper_cvalid", 32'(collisionValid), 32'h1);
    step();
    check("cvalid_one_cycle", 32'(collisionValid), 32'h0);

    // Transparent ball, flipper shows through.
    RGB_layers[0] = 8'hFF;
    RGB_layers[1] = 8'h03;
    draw          = 6'b000011;
    step();
    step();
    check("transp_rgb", 32'(RGB_screen), 32'h03);
    check("transp_drawany", 32'(drawAny), 32'h1);
    draw = '0;
    sof_pulse();
    check("transp_coll", 32'(collision), 32'h0);

    // No draws: background, then back-to-back frame pulses.
    step();
    step();
    check("bg_rgb", 32'(RGB_screen), 32'h92);
    check("bg_drawany", 32'(drawAny), 32'h0);
    startOfFrame = 1'b1;
    step();
    check("b2b_first_cvalid", 32'(collisionValid), 32'h1);
    check("b2b_first_coll", 32'(collision), 32'h0);
    step();
    startOfFrame = 1'b0;
    check("b2b_second_cvalid", 32'(collisionValid), 32'h1);
    check("b2b_second_coll", 32'(collision), 32'h0);

    // Disabled ball: bumper wins and no collision.
    RGB_layers[0] = 8'h1C;
    layerEnable   = 6'b111110;
    draw          = 6'b100001;
    step();
    step();
    check("disabled_rgb", 32'(RGB_screen), 32'hE0);
    draw        = '0;
    layerEnable = 6'b111111;
    sof_pulse();
    check("disabled_coll", 32'(collision), 32'h0);

    // Overlap only on the startOfFrame cycle counts for the closing frame.
    RGB_layers[4] = 8'h55;
    draw          = 6'b010001;
    startOfFrame  = 1'b1;
    step();
    startOfFrame  = 1'b0;
    draw          = '0;
    check("sof_hit_coll", 32'(collision), 32'h10);
    step();
    sof_pulse();
    check("sof_hit_next_frame", 32'(collision), 32'h0);

    // All layers effective: priority picks ball, every pair recorded.
    RGB_layers[2] = 8'h44;
    RGB_layers[3] = 8'h33;
    draw          = 6'b111111;
    step();
    step();
    check("all_rgb", 32'(RGB_screen), 32'h1C);
    draw = '0;
    sof_pulse();
    check("all_coll", 32'(collision), 32'h3E);

    // Accumulate hits, then reset mid-frame.
    draw = 6'b000011;
    step();
    step();
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_rgb", 32'(RGB_screen), 32'h0);
    check("midrst_drawany", 32'(drawAny), 32'h0);
    check("midrst_coll", 32'(collision), 32'h0);
    draw = '0;
    step();
    resetN = 1'b1;
    step();
    sof_pulse();
    check("midrst_next_coll", 32'(collision), 32'h0);

    // Blink: obstacle hidden for frames 0..31, visible 32..63, hidden at 64.
    do_reset();
    blinkMask = 6'b000100;
    draw      = 6'b000100;
    step();
    step();
    check("blink_f0_rgb", 32'(RGB_screen), 32'h92);
    check("blink_f0_drawany", 32'(drawAny), 32'h0);
    for (int n = 0; n < 31; n++) sof_pulse();
    check("blink_f31_rgb", 32'(RGB_screen), 32'h92);
    sof_pulse();
    step();
    check("blink_f32_rgb", 32'(RGB_screen), 32'h44);
    check("blink_f32_drawany", 32'(drawAny), 32'h1);
    for (int n = 0; n < 31; n++) sof_pulse();
    check("blink_f63_rgb", 32'(RGB_screen), 32'h44);
    sof_pulse();
    step();
    check("blink_f64_rgb", 32'(RGB_screen), 32'h92);
    check("blink_f64_drawany", 32'(drawAny), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
